// File: rtl/lut_mc_loadable.sv
// lut_mc_loadable: multi-channel loadable CDF/probability lookup table with post-reset clear; LUT_WR_FORWARD_EN enables write-first forwarding
module lut_mc_loadable #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_CH     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [NUM_CH-1:0]            rd_req,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CH-1:0]            rd_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   output logic                         ready,
   output logic                         busy_clear
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {CLEAR, READY} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic [DATA_WIDTH-1:0] rd_next [NUM_CH];
   // state register and clear counter; reset restarts the clear sweep from entry 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= busy_clear ? cnt_q + 1'b1 : cnt_q;
      end
   end
   // next state, status flags, and the shared table write port (clear sweep owns it while busy)
   always_comb begin
      state_d    = (state_q == CLEAR && cnt_q == '1) ? READY : state_q;
      ready      = state_q == READY;
      busy_clear = state_q == CLEAR;
      mem_we     = !reset && (busy_clear || wr_en);
      mem_wa     = busy_clear ? cnt_q : wr_addr;
      mem_wd     = busy_clear ? '0 : wr_data;
   end
   // table storage, no reset so it maps onto RAM
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end
   // per-channel lookup value, optionally bypassing a same-cycle write to the same entry
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef LUT_WR_FORWARD_EN
         rd_next[c] = (wr_en && wr_addr == rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]) ? wr_data : mem[rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]];
`else
         rd_next[c] = mem[rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
      end
   end
   // registered read outputs; data holds when a channel is idle
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= {NUM_CH{ready}} & rd_req;
         for (int c = 0; c < NUM_CH; c++)
            if (ready && rd_req[c]) rd_data[c*DATA_WIDTH +: DATA_WIDTH] <= rd_next[c];
      end
   end
endmodule

// File: tb/tb_lut_mc_loadable.sv
// tb_lut_mc_loadable: randomized scoreboard bench for lut_mc_loadable against a table-level model
module tb_lut_mc_loadable;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int NC = 2;
   localparam int DEPTH = 2**AW;
`ifdef LUT_WR_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   typedef struct {int ch; logic [DW-1:0] d;} exp_t;
   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [DW-1:0]    wr_data = '0;
   logic [NC-1:0]    rd_req = '0;
   logic [NC*AW-1:0] rd_addr = '0;
   logic [NC-1:0]    rd_valid;
   logic [NC*DW-1:0] rd_data;
   logic             ready;
   logic             busy_clear;
   int               tests = 0;
   int               fails = 0;
   int               clear_left = DEPTH;
   bit               mon_en = 1'b0;
   logic [DW-1:0]    ref_mem [DEPTH];
   logic [DW-1:0]    hold [NC];
   exp_t             sb [$];
   exp_t             me;

   lut_mc_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .ready(ready), .busy_clear(busy_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance the model at the edge, then check status and held data
   task automatic step(input bit rs, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NC-1:0] rq, input logic [NC*AW-1:0] ra);
      logic [NC-1:0] ev;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      exp_t          e;
      reset = rs; wr_en = we; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
      @(posedge clk);
      ev = '0;
      if (rs) begin
         clear_left = DEPTH;
         for (int c = 0; c < NC; c++) hold[c] = '0;
      end else if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
      end else begin
         for (int c = 0; c < NC; c++) if (rq[c]) begin
            a = ra[c*AW +: AW];
            d = (FWD && we && wa == a) ? wd : ref_mem[a];
            e.ch = c; e.d = d;
            sb.push_back(e);
            hold[c] = d;
            ev[c] = 1'b1;
         end
         if (we) ref_mem[wa] = wd;
      end
      #1;
      chk("ready", 32'(ready), 32'(clear_left == 0));
      chk("busy_clear", 32'(busy_clear), 32'(clear_left != 0));
      chk("rd_valid", 32'(rd_valid), 32'(ev));
      for (int c = 0; c < NC; c++)
         if (!ev[c]) chk($sformatf("hold_ch%0d", c), 32'(rd_data[c*DW +: DW]), 32'(hold[c]));
   endtask

   // monitor: every presented result is matched against the oldest expected entry
   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < NC; c++) if (rd_valid[c]) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL rd_unexpected ch%0d: got %0h expected no result", c, rd_data[c*DW +: DW]);
            end else begin
               me = sb.pop_front();
               if (me.ch != c || me.d !== rd_data[c*DW +: DW]) begin
                  fails++;
                  $display("FAIL rd_data ch%0d: got %0h expected ch%0d %0h", c, rd_data[c*DW +: DW], me.ch, me.d);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      step(1, 0, '0, '0, '0, '0);
      mon_en = 1'b1;
      n = 0;
      while (busy_clear && n < 600) begin
         step(0, 1, 8'h10, 16'hFFFF, 2'b11, {8'hFF, 8'h00});
         n++;
      end
      chk("clear_len", 32'(n), 32'd256);
      step(0, 0, '0, '0, 2'b11, {8'hFF, 8'h00});
      step(0, 0, '0, '0, 2'b01, {8'h00, 8'h10});
      step(0, 1, 8'h05, 16'h1234, 2'b00, '0);
      step(0, 1, 8'hA0, 16'hBEEF, 2'b00, '0);
      step(0, 0, '0, '0, 2'b11, {8'hA0, 8'h05});
      step(0, 0, '0, '0, 2'b00, '0);
      step(0, 0, '0, '0, 2'b11, {8'h05, 8'h05});
      step(0, 1, 8'h05, 16'h5555, 2'b01, {8'h00, 8'h05});
      step(0, 0, '0, '0, 2'b11, {8'h05, 8'h05});
      step(0, 1, 8'h05, 16'h1234, 2'b00, '0);
      step(1, 0, '0, '0, 2'b11, '0);
      repeat (100) step(0, 1, 8'h05, 16'hAAAA, 2'b11, {8'h05, 8'h05});
      step(1, 0, '0, '0, 2'b11, '0);
      n = 0;
      while (busy_clear && n < 600) begin
         step(0, 0, '0, '0, 2'b11, '0);
         n++;
      end
      chk("clear_len_restart", 32'(n), 32'd256);
      step(0, 0, '0, '0, 2'b11, {8'h10, 8'h05});
      repeat (400) begin
         logic [NC*AW-1:0] ra;
         for (int c = 0; c < NC; c++)
            ra[c*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         step(0, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom), NC'($urandom), ra);
      end
      step(0, 0, '0, '0, 2'b00, '0);
      #20;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lut_mc_loadable.md
Name: lut_mc_loadable

Overview:
- Parametrised lookup table for the arithmetic-encoder datapath, serving the probability/CDF tables used by the range coder.
- Adds to the plain combinational ROM:
  - NUM_CH independent read channels.
  - Registered reads with valid flags.
  - A runtime write port for loading table contents, since there is no init-file dependency.
  - An automatic clear sequence after reset.
- Sits between the table loader (testbench or host) and the encoder pipeline stages that consume the lookup values.

Parameters:
- DATA_WIDTH, 16, width of each table entry.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- NUM_CH, 2, number of independent read channels.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; accepted only when ready=1.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_req  input  NUM_CH  per-channel read request.
- rd_addr  input  NUM_CH*ADDR_WIDTH  packed read addresses; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_valid  output  NUM_CH  per-channel output-valid flag.
- rd_data  output  NUM_CH*DATA_WIDTH  packed read data; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready  output  1  high when the table is accepting reads and writes.
- busy_clear  output  1  high while the clear sequence runs.

Behaviour:
- Reset (reset=1 at a clk edge):
  - State goes to CLEAR; clear counter goes to 0.
  - ready=0, busy_clear=1, rd_valid=0, rd_data=0.
  - Reset is honoured in any state, including mid-CLEAR and mid-read. Any pending read result is dropped (rd_valid=0 next cycle).
- State CLEAR:
  - Each cycle, writes 0 to entry[counter], then increments the counter.
  - After writing entry 2**ADDR_WIDTH-1, goes to READY.
  - Lasts exactly 2**ADDR_WIDTH cycles: 256 at defaults.
  - wr_en and rd_req are ignored; rd_valid stays 0.
- State READY:
  - ready=1, busy_clear=0. Stays in READY until reset.
- Write: in READY with wr_en=1, entry[wr_addr] <= wr_data at the clk edge.
- Read, channel i: in READY with rd_req[i]=1 at edge N:
  - At edge N, rd_data[i] is registered from entry[rd_addr_i] and rd_valid[i] is set.
  - Both are visible after edge N (latency 1 cycle).
  - If rd_req[i]=0 at an edge, rd_valid[i] goes to 0 and rd_data[i] holds its previous value.
- Channels are fully independent. Any subset may read the same or different addresses in the same cycle with no arbitration or stall.
- Read-during-write to the same address in the same cycle (macro undefined): rd_data returns the OLD stored value. The new value is visible from the next read on.
- Address wrap: addresses are taken modulo depth by width; there is no out-of-range case.
- CLEAR to READY transition: the first cycle with ready=1 already accepts wr_en and rd_req.

Optional Feature:
- Macro: LUT_WR_FORWARD_EN.
- Defined: for a same-cycle read and write to an equal address in READY, each matching channel's rd_data returns wr_data (write-first forwarding). rd_valid timing is unchanged.
- Undefined: read-first behaviour as described in Behaviour.

Test Plan:
- Reset, then count cycles while holding rd_req=all 1s:
  - busy_clear=1 and ready=0 for exactly 256 cycles, with rd_valid=0 throughout.
  - Then ready=1.
  - Reads at addr 0x00 and 0xFF return 0x0000.
- In READY, write 0x1234 to 0x05 and 0xBEEF to 0xA0. Next cycle, ch0 reads 0x05 and ch1 reads 0xA0 together -> one cycle later rd_valid=2'b11, ch0=0x1234, ch1=0xBEEF.
- Both channels read 0x05 in the same cycle -> both return 0x1234, rd_valid=2'b11.
- Write 0x5555 to 0x05 while ch0 reads 0x05 in the same cycle:
  - Without the macro: 0x1234.
  - With LUT_WR_FORWARD_EN: 0x5555.
  - A read the following cycle returns 0x5555 in both builds.
- Assert reset at clear-counter 100, hold 1 cycle -> busy_clear remains 1 and the full 256-cycle CLEAR restarts. Previously written 0x1234 at 0x05 reads 0x0000 afterwards.
- During CLEAR, drive wr_en=1 with wr_addr=0x10 and wr_data=0xFFFF -> after CLEAR completes, 0x10 reads 0x0000 (write ignored).
